// File: rtl/tb_seq_pkg.sv
// Shared request codes and channel FSM encoding for the multi-channel sequence controller.
package tb_seq_pkg;

  typedef logic [1:0] code_t;

  localparam code_t CODE_DONE    = 2'b00;
  localparam code_t CODE_ONCE    = 2'b01;
  localparam code_t CODE_LOOPING = 2'b10;
  localparam code_t CODE_ABORT   = 2'b11;

  // State values match the status codes they report, so status is the state register itself.
  localparam logic [1:0] ST_IDLE     = 2'b00;
  localparam logic [1:0] ST_RUN_ONCE = 2'b01;
  localparam logic [1:0] ST_RUN_LOOP = 2'b10;

  function automatic logic is_start(input code_t code);
    return (code == CODE_ONCE) || (code == CODE_LOOPING);
  endfunction

endpackage

// File: rtl/tb_seq_chan.sv
// One sequence channel: FSM, phase counter, run counter and the done/abort/reject pulses.
module tb_seq_chan
  import tb_seq_pkg::*;
#(
  parameter int LEN_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trig_valid,
  input  logic [1:0]       trig_code,
  input  logic [LEN_W-1:0] seq_len,
  input  logic             cnt_clr,
  input  logic             grant_ok,
  output logic [1:0]       status,
  output logic [CNT_W-1:0] run_count,
  output logic [LEN_W-1:0] phase,
  output logic             done_pulse,
  output logic             abort_pulse,
  output logic             reject_pulse,
  output logic             active
);

  logic [1:0]       state_q, state_d;
  logic [LEN_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_d, abort_d, reject_d;
  logic             inc;
  logic [LEN_W-1:0] last_phase;
  logic             at_last, start_req, abort_req;

  always_comb begin
    // NOTE: every always_comb output is defaulted first so no path can infer a latch.
    state_d    = state_q;
    phase_d    = phase_q;
    inc        = 1'b0;
    done_d     = 1'b0;
    abort_d    = 1'b0;
    reject_d   = 1'b0;
    start_req  = trig_valid && is_start(trig_code);
    abort_req  = trig_valid && (trig_code == CODE_ABORT);
    // A length of 0 runs as 1; a phase at or past the end counts as the last one.
    last_phase = (seq_len == '0) ? '0 : seq_len - LEN_W'(1);
    at_last    = (phase_q >= last_phase);

    case (state_q)
      ST_RUN_ONCE, ST_RUN_LOOP: begin
        if (abort_req) begin
          state_d = ST_IDLE;
          phase_d = '0;
          abort_d = 1'b1;
        end else begin
          reject_d = start_req;
          if (!at_last) begin
            phase_d = phase_q + LEN_W'(1);
          end else if (state_q == ST_RUN_ONCE) begin
            state_d = ST_IDLE;
            phase_d = '0;
            done_d  = 1'b1;
          end else begin
            phase_d = '0;
            inc     = 1'b1;
          end
        end
      end
      default: begin
        if (start_req) begin
          if (grant_ok) begin
            state_d = (trig_code == CODE_ONCE) ? ST_RUN_ONCE : ST_RUN_LOOP;
            phase_d = '0;
            inc     = 1'b1;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
    endcase

    // Clear is applied first, so a coincident increment yields 1.
    cnt_d = (cnt_clr ? '0 : cnt_q) + (inc ? CNT_W'(1) : '0);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      phase_q      <= '0;
      cnt_q        <= '0;
      done_pulse   <= 1'b0;
      abort_pulse  <= 1'b0;
      reject_pulse <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      cnt_q        <= cnt_d;
      done_pulse   <= done_d;
      abort_pulse  <= abort_d;
      reject_pulse <= reject_d;
    end
  end

  assign status    = state_q;
  assign phase     = phase_q;
  assign run_count = cnt_q;
  assign active    = (state_q != ST_IDLE);

endmodule

// File: rtl/tb_seq_ctrl.sv
// Multi-channel sequence controller top: N_CH channels, busy OR and optional exclusion arbiter.
// Define TB_SEQ_EXCL_EN to allow only one non-idle channel at a time.
module tb_seq_ctrl
  import tb_seq_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int LEN_W = 8,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH-1:0]         trig_valid,
  input  logic [2*N_CH-1:0]       trig_code,
  input  logic [LEN_W-1:0]        seq_len,
  input  logic                    cnt_clr,
  output logic [2*N_CH-1:0]       status,
  output logic [N_CH*CNT_W-1:0]   run_count,
  output logic [N_CH*LEN_W-1:0]   phase,
  output logic [N_CH-1:0]         done_pulse,
  output logic [N_CH-1:0]         abort_pulse,
  output logic [N_CH-1:0]         reject_pulse,
  output logic                    any_busy
);

  logic [N_CH-1:0] active;
  logic [N_CH-1:0] grant_ok;

`ifdef TB_SEQ_EXCL_EN
  logic [N_CH-1:0] start_req;

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      start_req[i] = trig_valid[i] && is_start(trig_code[2*i +: 2]);
    end
  end

  // A start is granted only when no other channel is running and no lower index also asks.
  always_comb begin
    grant_ok = '0;
    for (int i = 0; i < N_CH; i++) begin
      grant_ok[i] = 1'b1;
      for (int j = 0; j < N_CH; j++) begin
        if (j != i && active[j]) grant_ok[i] = 1'b0;
        if (j < i && start_req[j]) grant_ok[i] = 1'b0;
      end
    end
  end
`else
  assign grant_ok = '1;
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    tb_seq_chan #(
      .LEN_W(LEN_W),
      .CNT_W(CNT_W)
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .trig_valid  (trig_valid[i]),
      .trig_code   (trig_code[2*i +: 2]),
      .seq_len     (seq_len),
      .cnt_clr     (cnt_clr),
      .grant_ok    (grant_ok[i]),
      .status      (status[2*i +: 2]),
      .run_count   (run_count[CNT_W*i +: CNT_W]),
      .phase       (phase[LEN_W*i +: LEN_W]),
      .done_pulse  (done_pulse[i]),
      .abort_pulse (abort_pulse[i]),
      .reject_pulse(reject_pulse[i]),
      .active      (active[i])
    );
  end

  assign any_busy = |active;

endmodule

// File: tb/tb_tb_seq_ctrl.sv
// Self-checking bench for tb_seq_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_tb_seq_ctrl;

  localparam int N_CH  = 4;
  localparam int LEN_W = 8;
  localparam int CNT_W = 16;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [N_CH-1:0]       trig_valid;
  logic [2*N_CH-1:0]     trig_code;
  logic [LEN_W-1:0]      seq_len;
  logic                  cnt_clr;
  logic [2*N_CH-1:0]     status;
  logic [N_CH*CNT_W-1:0] run_count;
  logic [N_CH*LEN_W-1:0] phase;
  logic [N_CH-1:0]       done_pulse, abort_pulse, reject_pulse;
  logic                  any_busy;

  tb_seq_ctrl #(.N_CH(N_CH), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .trig_valid(trig_valid), .trig_code(trig_code),
    .seq_len(seq_len), .cnt_clr(cnt_clr), .status(status), .run_count(run_count),
    .phase(phase), .done_pulse(done_pulse), .abort_pulse(abort_pulse),
    .reject_pulse(reject_pulse), .any_busy(any_busy)
  );

  always #5 clk = ~clk;

  // Model: mode 0 = done, 1 = once, 2 = looping (the reported status code).
  int          m_mode [N_CH];
  int          m_phase[N_CH];
  bit [15:0]   m_cnt  [N_CH];
  bit          m_done [N_CH];
  bit          m_abort[N_CH];
  bit          m_rej  [N_CH];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string nm, input int ch, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s ch%0d: got %0h expected %0h at %0t", nm, ch, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      m_mode[i] = 0; m_phase[i] = 0; m_cnt[i] = '0;
      m_done[i] = 0; m_abort[i] = 0; m_rej[i] = 0;
    end
  endtask

  task automatic model_step();
    bit busy_before[N_CH];
    bit start_any_lower;
    int len;
    len = (seq_len == 0) ? 1 : int'(seq_len);
    for (int i = 0; i < N_CH; i++) busy_before[i] = (m_mode[i] != 0);
    start_any_lower = 0;
    for (int i = 0; i < N_CH; i++) begin
      int  code;
      bit  start, abort, granted, inc;
      code    = int'(trig_code[2*i +: 2]);
      start   = trig_valid[i] && (code == 1 || code == 2);
      abort   = trig_valid[i] && (code == 3);
      granted = 1;
`ifdef TB_SEQ_EXCL_EN
      for (int j = 0; j < N_CH; j++) if (j != i && busy_before[j]) granted = 0;
      if (start_any_lower) granted = 0;
`endif
      if (start) start_any_lower = 1;
      inc = 0;
      m_done[i] = 0; m_abort[i] = 0; m_rej[i] = 0;
      if (m_mode[i] == 0) begin
        if (start && granted) begin
          m_mode[i] = code; m_phase[i] = 0; inc = 1;
        end else if (start) begin
          m_rej[i] = 1;
        end
      end else if (abort) begin
        m_mode[i] = 0; m_phase[i] = 0; m_abort[i] = 1;
      end else begin
        m_rej[i] = start;
        if (m_phase[i] + 1 < len) m_phase[i]++;
        else if (m_mode[i] == 1) begin
          m_mode[i] = 0; m_phase[i] = 0; m_done[i] = 1;
        end else begin
          m_phase[i] = 0; inc = 1;
        end
      end
      m_cnt[i] = (cnt_clr ? 16'h0 : m_cnt[i]) + (inc ? 16'h1 : 16'h0);
    end
  endtask

  task automatic compare_all();
    bit busy;
    busy = 0;
    for (int i = 0; i < N_CH; i++) begin
      check("status",    i, 32'(status[2*i +: 2]),            32'(m_mode[i]));
      check("phase",     i, 32'(phase[LEN_W*i +: LEN_W]),     32'(m_phase[i]));
      check("run_count", i, 32'(run_count[CNT_W*i +: CNT_W]), 32'(m_cnt[i]));
      check("done",      i, 32'(done_pulse[i]),               32'(m_done[i]));
      check("abort",     i, 32'(abort_pulse[i]),              32'(m_abort[i]));
      check("reject",    i, 32'(reject_pulse[i]),             32'(m_rej[i]));
      if (m_mode[i] != 0) busy = 1;
    end
    check("any_busy", 0, 32'(any_busy), 32'(busy));
  endtask

  // One clock: DUT and model both consume the inputs at the edge, then outputs are compared.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic trig(input int ch, input logic [1:0] code);
    trig_valid[ch]       = 1'b1;
    trig_code[2*ch +: 2] = code;
  endtask

  task automatic idle_inputs();
    trig_valid = '0;
    trig_code  = '0;
    cnt_clr    = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    seq_len = 8'd3;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    compare_all();
    cycle();

    // ch0 ONCE of length 3, then a second run with a start strobe on its completion cycle.
    trig(0, 2'b01); cycle(); idle_inputs();
    check("lit_once_status", 0, 32'(status[1:0]), 32'h1);
    cycle(); cycle();
    check("lit_once_phase2", 0, 32'(phase[7:0]), 32'h2);
    cycle();
    check("lit_once_done", 0, 32'(done_pulse[0]), 32'h1);
    check("lit_once_cnt", 0, 32'(run_count[15:0]), 32'h1);
    check("lit_once_idle", 0, 32'(status[1:0]), 32'h0);
    trig(0, 2'b01); cycle(); idle_inputs();
    cycle(); cycle();
    trig(0, 2'b01); cycle(); idle_inputs();
    check("lit_late_reject", 0, 32'(reject_pulse[0]), 32'h1);
    check("lit_late_cnt", 0, 32'(run_count[15:0]), 32'h2);
    check("lit_late_idle", 0, 32'(status[1:0]), 32'h0);

    // ch2 LOOPING of length 2 for 7 cycles, then ABORT.
    seq_len = 8'd2;
    trig(2, 2'b10); cycle(); idle_inputs();
    repeat (6) cycle();
    check("lit_loop_cnt", 2, 32'(run_count[47:32]), 32'h4);
    trig(2, 2'b11); cycle(); idle_inputs();
    check("lit_abort_pulse", 2, 32'(abort_pulse[2]), 32'h1);
    check("lit_abort_idle", 2, 32'(status[5:4]), 32'h0);
    check("lit_abort_nodone", 2, 32'(done_pulse[2]), 32'h0);
    check("lit_abort_cnt", 2, 32'(run_count[47:32]), 32'h4);
    cycle();

    // Asynchronous reset in the middle of a ch1 loop at phase 2.
    seq_len = 8'd4;
    trig(1, 2'b10); cycle(); idle_inputs();
    cycle(); cycle();
    check("lit_pre_rst_phase", 1, 32'(phase[15:8]), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    check("lit_rst_status", 0, 32'(status), 32'h0);
    check("lit_rst_cnt", 0, 32'(run_count[31:0] | run_count[63:32]), 32'h0);
    check("lit_rst_phase", 0, 32'(phase), 32'h0);
    check("lit_rst_busy", 0, 32'(any_busy), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    compare_all();
    cycle();

    // seq_len 0 runs as 1; then a ch3 loop wraps the run counter.
    seq_len = 8'd0;
    trig(3, 2'b01); cycle(); idle_inputs();
    check("lit_len0_status", 3, 32'(status[7:6]), 32'h1);
    cycle();
    check("lit_len0_done", 3, 32'(done_pulse[3]), 32'h1);
    check("lit_len0_cnt", 3, 32'(run_count[63:48]), 32'h1);
    seq_len = 8'd1;
    trig(3, 2'b10); cycle(); idle_inputs();
    check("lit_loop_start_cnt", 3, 32'(run_count[63:48]), 32'h2);
    cnt_clr = 1'b1; cycle(); idle_inputs();
    check("lit_clr_inc", 3, 32'(run_count[63:48]), 32'h1);
    repeat (65534) cycle();
    check("lit_cnt_max", 3, 32'(run_count[63:48]), 32'hFFFF);
    cycle();
    check("lit_cnt_wrap", 3, 32'(run_count[63:48]), 32'h0);
    trig(3, 2'b11); cycle(); idle_inputs();
    cycle();

`ifdef TB_SEQ_EXCL_EN
    seq_len = 8'd5;
    trig(1, 2'b01); trig(3, 2'b01); cycle(); idle_inputs();
    check("lit_excl_grant", 1, 32'(status[3:2]), 32'h1);
    check("lit_excl_rej3", 3, 32'(reject_pulse[3]), 32'h1);
    trig(0, 2'b01); cycle(); idle_inputs();
    check("lit_excl_rej0", 0, 32'(reject_pulse[0]), 32'h1);
    repeat (6) cycle();
`endif

    // Random traffic with occasional length changes and counter clears.
    for (int n = 0; n < 3000; n++) begin
      idle_inputs();
      for (int i = 0; i < N_CH; i++) begin
        if ($urandom_range(5) == 0) begin
          trig_valid[i]       = 1'b1;
          trig_code[2*i +: 2] = 2'($urandom_range(3));
        end
      end
      if ($urandom_range(19) == 0) seq_len = 8'($urandom_range(6));
      cnt_clr = ($urandom_range(49) == 0);
      cycle();
    end
    idle_inputs();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
